// File: rtl/result_uart_tx_pkg.sv
// Shared types and defaults for the result UART reporter.
package result_uart_tx_pkg;

    localparam int         FRAME_BYTES          = 9;
    localparam int         CLKS_PER_BIT_DEFAULT = 868;   // 100 MHz / 115200
    localparam logic [7:0] SYNC_BYTE_DEFAULT    = 8'hA5;

    typedef enum logic [1:0] {
        F_IDLE,
        F_SEND,
        F_DONE
    } frame_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } byte_state_t;

    function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                              input logic [7:0]  sync,
                                              input logic [31:0] v0,
                                              input logic [31:0] v1);
        logic [7:0] b;
        case (idx)
            4'd0:    b = sync;
            4'd1:    b = v0[31:24];
            4'd2:    b = v0[23:16];
            4'd3:    b = v0[15:8];
            4'd4:    b = v0[7:0];
            4'd5:    b = v1[31:24];
            4'd6:    b = v1[23:16];
            4'd7:    b = v1[15:8];
            4'd8:    b = v1[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/result_uart_tx_uart_byte_tx.sv
// 8N1 byte serializer, LSB first; Tx is registered and trails the state by one cycle.
// state   | meaning
// B_IDLE  | line high, waiting for Start
// B_START | start bit (0)
// B_DATA  | data bits d0..d7
// B_STOP  | stop bit (1); may chain straight into the next byte
module uart_byte_tx
    import result_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Data,
    input  logic       Start,
    output logic       Tx,
    output logic       Done
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(CLKS_PER_BIT - 2);

    byte_state_t   state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    data_q;
    logic          tx_q;
    logic          bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= B_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                B_IDLE: begin
                    tx_q <= 1'b1;
                    if (Start) begin
                        data_q  <= Data;
                        cnt_q   <= '0;
                        state_q <= B_START;
                    end
                end
                B_START: begin
                    tx_q <= 1'b0;
                    if (bit_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= B_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                B_DATA: begin
                    tx_q <= data_q[bit_q];
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) state_q <= B_STOP;
                        else               bit_q   <= bit_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                B_STOP: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (Start) begin
                            data_q  <= Data;
                            state_q <= B_START;
                        end else begin
                            state_q <= B_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= B_IDLE;
            endcase
        end
    end

    // Done leads the end of the stop bit so the caller can present the next byte in time.
    assign Done = (state_q == B_STOP) && (cnt_q == CNT_DONE);
    assign Tx   = tx_q;

endmodule

// File: rtl/result_uart_tx.sv
// Sends a 9-byte snapshot of v0/v1 over UART whenever either value changes or a send is forced.
// state  | meaning
// F_IDLE | compare inputs against snapshot, launch on trigger
// F_SEND | feeding bytes 0..8 to the serializer
// F_DONE | frame complete, bump counter
module result_uart_tx
    import result_uart_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] v0_In,
    input  logic [31:0] v1_In,
    input  logic        Force_Send,
    output logic        Tx,
    output logic        Busy,
    output logic [7:0]  Frames_Sent
);

    frame_state_t f_state_q;
    logic [31:0]  snap_v0_q;
    logic [31:0]  snap_v1_q;
    logic [3:0]   byte_idx_q;
    logic         pend_q;
    logic         busy_q;
    logic [1:0]   launch_q;
    logic [7:0]   frames_q;
    logic         trig;
    logic         launch;
    logic         byte_done;
    logic         byte_start;
    logic [7:0]   byte_data;

    assign trig       = Force_Send | pend_q | (v0_In != snap_v0_q) | (v1_In != snap_v1_q);
    assign launch     = (f_state_q == F_IDLE) && trig;
    assign byte_start = (f_state_q == F_SEND);
    assign byte_data  = frame_byte(byte_idx_q, SYNC_BYTE, snap_v0_q, snap_v1_q);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            f_state_q  <= F_IDLE;
            snap_v0_q  <= '0;
            snap_v1_q  <= '0;
            byte_idx_q <= '0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            launch_q   <= '0;
            frames_q   <= '0;
        end else begin
            // launch_q tracks the two-cycle hop from trigger to the first start bit
            launch_q <= {launch_q[0], launch};
            pend_q   <= (f_state_q != F_IDLE) ? (pend_q | Force_Send) : 1'b0;

            if (f_state_q == F_IDLE) busy_q <= 1'b0;
            else if (launch_q[1])    busy_q <= 1'b1;

            case (f_state_q)
                F_IDLE: begin
                    if (trig) begin
                        snap_v0_q  <= v0_In;
                        snap_v1_q  <= v1_In;
                        byte_idx_q <= '0;
                        f_state_q  <= F_SEND;
                    end
                end
                F_SEND: begin
                    if (byte_done) begin
                        if (byte_idx_q == 4'(FRAME_BYTES - 1)) f_state_q  <= F_DONE;
                        else                                   byte_idx_q <= byte_idx_q + 4'd1;
                    end
                end
                F_DONE: begin
                    frames_q  <= frames_q + 8'd1;
                    f_state_q <= F_IDLE;
                end
                default: f_state_q <= F_IDLE;
            endcase
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .Clk  (Clk),
        .Reset(Reset),
        .Data (byte_data),
        .Start(byte_start),
        .Tx   (Tx),
        .Done (byte_done)
    );

    assign Busy        = busy_q;
    assign Frames_Sent = frames_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Randomized bench: timing/content reference model plus a UART line decoder.
module tb_result_uart_tx;

    localparam int C     = 4;
    localparam int FRAME = 90 * C;

    logic        Clk        = 1'b0;
    logic        Reset      = 1'b0;
    logic        Force_Send = 1'b0;
    logic [31:0] v0_In      = '0;
    logic [31:0] v1_In      = '0;
    logic        Tx;
    logic        Busy;
    logic [7:0]  Frames_Sent;

    result_uart_tx #(
        .CLKS_PER_BIT(C),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .v0_In      (v0_In),
        .v1_In      (v1_In),
        .Force_Send (Force_Send),
        .Tx         (Tx),
        .Busy       (Busy),
        .Frames_Sent(Frames_Sent)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [71:0] data;
        int          t0;
    } frame_t;

    // Reference model: frame start edge N -> Tx low at N+2, Busy over [N+2, N+2+FRAME),
    // counter bump at N+FRAME+1, next launch possible at N+FRAME+2.
    int          cyc       = 0;
    logic [31:0] m_snap0   = '0;
    logic [31:0] m_snap1   = '0;
    bit          m_pend    = 0;
    int          m_free    = 0;
    int          m_done_at = -1;
    int          m_busy_lo = 0;
    int          m_busy_hi = 0;
    logic [7:0]  m_fs      = '0;
    frame_t      exp_q[$];
    bit          chk_en    = 0;

    always @(posedge Clk) begin
        cyc++;
        if (!Reset) begin
            m_snap0   = '0;
            m_snap1   = '0;
            m_pend    = 0;
            m_free    = 0;
            m_done_at = -1;
            m_busy_lo = 0;
            m_busy_hi = 0;
            m_fs      = '0;
            exp_q.delete();
        end else begin
            if (cyc == m_done_at) m_fs = m_fs + 8'd1;
            if (cyc >= m_free) begin
                if (Force_Send || m_pend || v0_In != m_snap0 || v1_In != m_snap1) begin
                    m_snap0   = v0_In;
                    m_snap1   = v1_In;
                    m_pend    = 0;
                    exp_q.push_back('{data: {8'hA5, v0_In, v1_In}, t0: cyc + 2});
                    m_busy_lo = cyc + 2;
                    m_busy_hi = cyc + 2 + FRAME;
                    m_done_at = cyc + FRAME + 1;
                    m_free    = cyc + FRAME + 2;
                end
            end else if (Force_Send) begin
                m_pend = 1;
            end
        end
    end

    bit bexp;
    always @(negedge Clk) begin
        if (chk_en) begin
            bexp = (cyc >= m_busy_lo) && (cyc < m_busy_hi);
            check_eq("busy", 72'(Busy), 72'(bexp));
            check_eq("frames_sent", 72'(Frames_Sent), 72'(m_fs));
            if (!bexp) check_eq("tx_idle", 72'(Tx), 72'(1'b1));
        end
    end

    // Line decoder: samples mid-bit, assembles 9-byte frames, compares to the model queue.
    bit          rx_act    = 0;
    int          rx_cnt    = 0;
    int          rx_n      = 0;
    int          rx_t0     = 0;
    int          rx_k      = 0;
    int          rx_frames = 0;
    logic [7:0]  rx_byte   = '0;
    logic [71:0] rx_frame  = '0;
    frame_t      rx_exp;

    always @(negedge Clk) begin
        if (!chk_en || !Reset) begin
            rx_act = 0;
            rx_n   = 0;
        end else if (!rx_act) begin
            if (Tx == 1'b0) begin
                rx_act = 1;
                rx_cnt = 0;
                if (rx_n == 0) rx_t0 = cyc;
                check_eq("byte_start_time", 72'(cyc), 72'(rx_t0 + 10 * C * rx_n));
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % C == C / 2) begin
                rx_k = rx_cnt / C;
                if (rx_k == 0) begin
                    check_eq("start_bit", 72'(Tx), 72'(1'b0));
                end else if (rx_k <= 8) begin
                    rx_byte[rx_k-1] = Tx;
                end else begin
                    check_eq("stop_bit", 72'(Tx), 72'(1'b1));
                    rx_act   = 0;
                    rx_frame = {rx_frame[63:0], rx_byte};
                    rx_n++;
                    if (rx_n == 9) begin
                        rx_n = 0;
                        rx_frames++;
                        check_eq("frame_expected", 72'(exp_q.size() != 0), 72'(1'b1));
                        if (exp_q.size() != 0) begin
                            rx_exp = exp_q.pop_front();
                            check_eq("frame_data", rx_frame, rx_exp.data);
                            check_eq("frame_start", 72'(rx_t0), 72'(rx_exp.t0));
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic pulse_force();
        Force_Send = 1'b1;
        tick(1);
        Force_Send = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n  = 0;
        bit ok = 0;
        while (n < 3000 && !ok) begin
            tick(1);
            n++;
            ok = (cyc >= m_free) && !m_pend && (v0_In == m_snap0) && (v1_In == m_snap1)
                 && (exp_q.size() == 0) && !rx_act;
        end
        check_eq(tag, 72'(ok), 72'(1'b1));
        tick(2);
    endtask

    initial begin
        tick(5);
        chk_en = 1;
        check_eq("rst_tx", 72'(Tx), 72'(1'b1));
        check_eq("rst_busy", 72'(Busy), 72'(1'b0));
        check_eq("rst_fs", 72'(Frames_Sent), 72'(0));
        Reset = 1'b1;
        tick(1000);
        check_eq("idle_no_frames", 72'(rx_frames), 72'(0));

        // first frame, latency, and a mid-frame v1 change
        v0_In = 32'h12345678;
        tick(1);
        check_eq("lat_n0", 72'(Tx), 72'(1'b1));
        tick(1);
        check_eq("lat_n1", 72'(Tx), 72'(1'b1));
        tick(1);
        check_eq("lat_n2", 72'(Tx), 72'(1'b0));
        check_eq("lat_busy", 72'(Busy), 72'(1'b1));
        tick(98);
        v1_In = 32'h000000FF;
        wait_idle("idle_after_change");
        check_eq("fs_two", 72'(Frames_Sent), 72'(2));

        pulse_force();
        wait_idle("idle_after_force");
        check_eq("fs_force", 72'(Frames_Sent), 72'(3));

        v0_In = 32'hCAFEF00D;
        pulse_force();
        wait_idle("idle_after_force_chg");
        check_eq("fs_force_chg", 72'(Frames_Sent), 72'(4));

        pulse_force();
        tick(50);
        pulse_force();
        wait_idle("idle_after_pending");
        check_eq("fs_pending", 72'(Frames_Sent), 72'(6));

        // reset during a data bit of byte 1
        v0_In = 32'h12345678;
        tick(54);
        Reset = 1'b0;
        tick(1);
        check_eq("midrst_tx", 72'(Tx), 72'(1'b1));
        check_eq("midrst_busy", 72'(Busy), 72'(1'b0));
        check_eq("midrst_fs", 72'(Frames_Sent), 72'(0));
        Reset = 1'b1;
        wait_idle("idle_after_reset");
        check_eq("fs_after_reset", 72'(Frames_Sent), 72'(1));

        for (int i = 0; i < 40; i++) begin
            tick(int'($urandom_range(0, 400)));
            case ($urandom_range(0, 9))
                0, 1, 2: v0_In = $urandom();
                3, 4:    v1_In = $urandom();
                5, 6:    pulse_force();
                7: begin
                    v0_In = $urandom();
                    pulse_force();
                end
                8: begin
                    v1_In = v1_In ^ 32'h1;
                    tick(1);
                    v1_In = v1_In ^ 32'h1;
                end
                default: begin
                    Reset = 1'b0;
                    tick(1);
                    Reset = 1'b1;
                end
            endcase
        end
        wait_idle("idle_final");
        check_eq("exp_q_empty", 72'(exp_q.size()), 72'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
